// File: rtl/rbe_engine_sequencer.sv
// rbe_engine_sequencer: control FSM for one output tile of the engine core.
// The sequence is: clear the accumulators, load an activation tile, then stream
// weight bit-planes over the QA x QW bit loop for each Kin tile. An optional
// norm word follows. The block then waits until every column has accepted
// the output.
module rbe_engine_sequencer #(
  parameter int unsigned NR_COLUMN = 9,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned QMAX      = 8,
  localparam int unsigned QCFG_W   = $clog2(QMAX) + 1,
  localparam int unsigned IDX_W    = $clog2(QMAX)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clear_i,
  input  logic                 start_i,
  input  logic [CNT_W-1:0]     cfg_nb_kin_i,
  input  logic [QCFG_W-1:0]    cfg_qa_i,
  input  logic [QCFG_W-1:0]    cfg_qw_i,
  input  logic                 cfg_norm_en_i,
  input  logic                 act_valid_i,
  output logic                 act_ready_o,
  input  logic                 wgt_valid_i,
  output logic                 wgt_ready_o,
  input  logic                 norm_valid_i,
  output logic                 norm_ready_o,
  output logic                 out_valid_o,
  input  logic [NR_COLUMN-1:0] out_ready_i,
  output logic                 acc_clear_o,
  output logic                 acc_en_o,
  output logic [CNT_W-1:0]     kin_idx_o,
  output logic [IDX_W-1:0]     qa_idx_o,
  output logic [IDX_W-1:0]     qw_idx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_LOAD,
    S_COMP,
    S_NORM,
    S_STREAM,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     kin_last_q, kin_q;
  logic [IDX_W-1:0]     qa_last_q, qw_last_q, qa_q, qw_q;
  logic                 norm_en_q;
  logic [NR_COLUMN-1:0] mask_q;

  logic act_hs, wgt_hs, norm_hs;
  logic qw_wrap, qa_wrap, kin_wrap, stream_full;

  // The last valid bit index: 0 means 1 bit; anything above QMAX clamps to QMAX bits.
  function automatic logic [IDX_W-1:0] bits_to_last(input logic [QCFG_W-1:0] v);
    if (v == '0)
      return '0;
    else if (v > QCFG_W'(QMAX))
      return IDX_W'(QMAX - 1);
    else
      return IDX_W'(v - QCFG_W'(1));
  endfunction

  assign act_hs      = act_valid_i & act_ready_o;
  assign wgt_hs      = wgt_valid_i & wgt_ready_o;
  assign norm_hs     = norm_valid_i & norm_ready_o;
  assign qw_wrap     = (qw_q == qw_last_q);
  assign qa_wrap     = (qa_q == qa_last_q);
  assign kin_wrap    = (kin_q == kin_last_q);
  assign stream_full = &(mask_q | out_ready_i);

  assign acc_en_o  = wgt_hs;
  assign kin_idx_o = kin_q;
  assign qa_idx_o  = qa_q;
  assign qw_idx_o  = qw_q;

  // Next-state selection; reset and clear override every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start_i) state_d = S_CLR;
      S_CLR:    state_d = S_LOAD;
      S_LOAD:   if (act_hs) state_d = S_COMP;
      S_COMP: begin
        if (wgt_hs && qw_wrap && qa_wrap) begin
          if (!kin_wrap)
            state_d = S_LOAD;
          else if (norm_en_q)
            state_d = S_NORM;
          else
            state_d = S_STREAM;
        end
      end
      S_NORM:   if (norm_hs) state_d = S_STREAM;
      S_STREAM: if (stream_full) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (rst_i || clear_i) state_d = S_IDLE;
  end

  // State, loop counters, latched config, column mask, and registered control outputs.
  // The outputs are decoded from the next state. As a result, each one is valid in
  // the same cycle as the state it belongs to.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q      <= S_IDLE;
      kin_q        <= '0;
      qa_q         <= '0;
      qw_q         <= '0;
      kin_last_q   <= '0;
      qa_last_q    <= '0;
      qw_last_q    <= '0;
      norm_en_q    <= 1'b0;
      mask_q       <= '0;
      act_ready_o  <= 1'b0;
      wgt_ready_o  <= 1'b0;
      norm_ready_o <= 1'b0;
      out_valid_o  <= 1'b0;
      acc_clear_o  <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_ready_o  <= (state_d == S_LOAD);
      wgt_ready_o  <= (state_d == S_COMP);
      norm_ready_o <= (state_d == S_NORM);
      out_valid_o  <= (state_d == S_STREAM);
      acc_clear_o  <= (state_d == S_CLR);
      busy_o       <= (state_d != S_IDLE);
      done_o       <= (state_d == S_DONE);

      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            kin_last_q <= (cfg_nb_kin_i == '0) ? '0 : cfg_nb_kin_i - CNT_W'(1);
            qa_last_q  <= bits_to_last(cfg_qa_i);
            qw_last_q  <= bits_to_last(cfg_qw_i);
            norm_en_q  <= cfg_norm_en_i;
          end
        end
        S_CLR: begin
          kin_q <= '0;
          qa_q  <= '0;
          qw_q  <= '0;
        end
        S_COMP: begin
          if (wgt_hs) begin
            if (qw_wrap) begin
              qw_q <= '0;
              if (qa_wrap) begin
                qa_q <= '0;
                if (!kin_wrap) kin_q <= kin_q + CNT_W'(1);
              end else begin
                qa_q <= qa_q + IDX_W'(1);
              end
            end else begin
              qw_q <= qw_q + IDX_W'(1);
            end
          end
        end
        S_STREAM: begin
          if (stream_full)
            mask_q <= '0;
          else
            mask_q <= mask_q | out_ready_i;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rbe_engine_sequencer.sv
// Self-checking bench for rbe_engine_sequencer. It uses directed scenarios with
// randomized handshake stalls. Expectations come from a loop-nest model of the
// tile schedule and from a model of the column accepts.
module tb_rbe_engine_sequencer;

  localparam int NRC = 9;
  localparam int CW  = 16;
  localparam int QM  = 8;
  localparam int QCW = 4;
  localparam int IW  = 3;

  logic           clk = 1'b0;
  logic           rst_i = 1'b0, clear_i = 1'b0, start_i = 1'b0;
  logic [CW-1:0]  cfg_nb_kin_i = '0;
  logic [QCW-1:0] cfg_qa_i = '0, cfg_qw_i = '0;
  logic           cfg_norm_en_i = 1'b0;
  logic           act_valid_i = 1'b0, wgt_valid_i = 1'b0, norm_valid_i = 1'b0;
  logic [NRC-1:0] out_ready_i = '0;
  logic           act_ready_o, wgt_ready_o, norm_ready_o, out_valid_o;
  logic           acc_clear_o, acc_en_o, busy_o, done_o;
  logic [CW-1:0]  kin_idx_o;
  logic [IW-1:0]  qa_idx_o, qw_idx_o;

  always #5 clk = ~clk;

  rbe_engine_sequencer #(.NR_COLUMN(NRC), .CNT_W(CW), .QMAX(QM)) dut (
    .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .cfg_nb_kin_i(cfg_nb_kin_i), .cfg_qa_i(cfg_qa_i), .cfg_qw_i(cfg_qw_i),
    .cfg_norm_en_i(cfg_norm_en_i),
    .act_valid_i(act_valid_i), .act_ready_o(act_ready_o),
    .wgt_valid_i(wgt_valid_i), .wgt_ready_o(wgt_ready_o),
    .norm_valid_i(norm_valid_i), .norm_ready_o(norm_ready_o),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .acc_clear_o(acc_clear_o), .acc_en_o(acc_en_o),
    .kin_idx_o(kin_idx_o), .qa_idx_o(qa_idx_o), .qw_idx_o(qw_idx_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  int n_cmp = 0, n_err = 0, cyc = 0;
  int act_cnt, en_cnt, norm_cnt, ov_cnt, done_cnt, clr_cnt, exp_ov;
  int t_start, t_clr, t_act, t_en, t_ov, t_ov_last, t_norm, t_done;
  logic [NRC-1:0] or_acc;
  logic [CW+2*IW-1:0] obs_q[$], exp_q[$];
  logic [NRC-1:0] pat[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    act_cnt = 0; en_cnt = 0; norm_cnt = 0; ov_cnt = 0; done_cnt = 0; clr_cnt = 0; exp_ov = 0;
    t_clr = -1; t_act = -1; t_en = -1; t_ov = -1; t_ov_last = -1; t_norm = -1; t_done = -1;
    or_acc = '0;
    obs_q.delete();
  endtask

  task automatic step();
    @(negedge clk);
    chk("ready_exclusive", 64'($countones({act_ready_o, wgt_ready_o, norm_ready_o}) <= 1), 1);
    chk("acc_en_rule", acc_en_o, wgt_valid_i & wgt_ready_o);
    if (acc_clear_o) begin clr_cnt++; if (t_clr < 0) t_clr = cyc; end
    if (act_valid_i && act_ready_o) begin act_cnt++; if (t_act < 0) t_act = cyc; end
    if (acc_en_o) begin
      en_cnt++;
      obs_q.push_back({kin_idx_o, qa_idx_o, qw_idx_o});
      if (t_en < 0) t_en = cyc;
    end
    if (norm_valid_i && norm_ready_o) begin norm_cnt++; t_norm = cyc; end
    if (out_valid_o) begin
      ov_cnt++;
      t_ov_last = cyc;
      if (t_ov < 0) t_ov = cyc;
      or_acc |= out_ready_i;
      if (&or_acc && exp_ov == 0) exp_ov = ov_cnt;
    end
    if (done_o) begin done_cnt++; if (t_done < 0) t_done = cyc; end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // omode: 0 all columns ready, 1 random per-column ready, 2 scripted pattern while out_valid
  task automatic drive(input int vpct, input int omode);
    act_valid_i  = ($urandom_range(99) < vpct);
    wgt_valid_i  = ($urandom_range(99) < vpct);
    norm_valid_i = ($urandom_range(99) < vpct);
    case (omode)
      0: out_ready_i = '1;
      1: for (int b = 0; b < NRC; b++) out_ready_i[b] = ($urandom_range(99) < 35);
      default: out_ready_i = (out_valid_o && pat.size() > 0) ? pat.pop_front() : '0;
    endcase
  endtask

  task automatic run(input int nb, input int qa, input int qw, input bit ne,
                     input int vpct, input int omode, input int restart_at);
    clear_stats();
    cfg_nb_kin_i = CW'(nb); cfg_qa_i = QCW'(qa); cfg_qw_i = QCW'(qw); cfg_norm_en_i = ne;
    start_i = 1'b1;
    t_start = cyc;
    drive(vpct, omode);
    step();
    for (int i = 0; i < 3000 && done_cnt == 0; i++) begin
      if (i == restart_at) begin
        start_i = 1'b1;
        cfg_nb_kin_i = CW'(1); cfg_qa_i = QCW'(1); cfg_qw_i = QCW'(1); cfg_norm_en_i = ~ne;
      end else begin
        start_i = 1'b0;
      end
      drive(vpct, omode);
      step();
    end
    start_i = 1'b0;
    chk("run_reaches_done", done_cnt, 1);
    drive(vpct, omode);
    step();
    chk("idle_after_done", {busy_o, done_o}, 2'b00);
  endtask

  task automatic check_run(input string tag, input int nb, input int qa, input int qw, input bit ne);
    int nbc, qac, qwc;
    nbc = (nb == 0) ? 1 : nb;
    qac = (qa == 0) ? 1 : (qa > QM ? QM : qa);
    qwc = (qw == 0) ? 1 : (qw > QM ? QM : qw);
    exp_q.delete();
    for (int k = 0; k < nbc; k++)
      for (int a = 0; a < qac; a++)
        for (int w = 0; w < qwc; w++)
          exp_q.push_back({CW'(k), IW'(a), IW'(w)});
    chk({tag, "_act_hs"}, act_cnt, nbc);
    chk({tag, "_acc_en"}, en_cnt, nbc * qac * qwc);
    chk({tag, "_seq_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk({tag, "_seq"}, obs_q[i], exp_q[i]);
    chk({tag, "_norm_hs"}, norm_cnt, ne ? 1 : 0);
    chk({tag, "_clr"}, clr_cnt, 1);
    chk({tag, "_stream_len"}, ov_cnt, exp_ov);
    chk({tag, "_done_lat"}, t_done, t_ov_last + 1);
    if (ne) chk({tag, "_norm_before_out"}, t_norm < t_ov, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    @(posedge clk); #1;

    // reset state
    rst_i = 1'b1; step(); step();
    chk("reset_outputs", {act_ready_o, wgt_ready_o, norm_ready_o, out_valid_o, acc_clear_o,
                          acc_en_o, kin_idx_o, qa_idx_o, qw_idx_o, busy_o, done_o}, '0);
    rst_i = 1'b0;

    // minimal tile latencies
    run(1, 1, 1, 0, 100, 0, -1);
    chk("lat_clr", t_clr, t_start + 1);
    chk("lat_act", t_act, t_start + 2);
    chk("lat_en", t_en, t_start + 3);
    chk("lat_out", t_ov, t_start + 4);
    chk("lat_done", t_done, t_start + 5);
    check_run("min", 1, 1, 1, 0);

    // multi-tile loop with norm and random stalls
    run(3, 4, 2, 1, 50, 1, -1);
    check_run("k3q4q2", 3, 4, 2, 1);

    // staggered column accepts
    pat.delete(); pat.push_back(9'h00F); pat.push_back(9'h0F0); pat.push_back(9'h100);
    run(1, 1, 1, 0, 100, 2, -1);
    chk("stagger_ov_cycles", ov_cnt, 3);
    chk("stagger_done_cycle", t_done, t_ov + 3);

    // clamping of zero / oversized config
    run(0, 0, 15, 0, 100, 0, -1);
    check_run("clamp", 0, 0, 15, 0);

    // start while busy is ignored, including the new config
    run(2, 3, 2, 0, 100, 0, 5);
    check_run("restart_ignored", 2, 3, 2, 0);

    // clear in COMP at qa_idx==2 aborts silently
    clear_stats();
    cfg_nb_kin_i = CW'(1); cfg_qa_i = QCW'(4); cfg_qw_i = QCW'(1); cfg_norm_en_i = 1'b0;
    start_i = 1'b1; drive(100, 0); step(); start_i = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      drive(100, 0);
      if (wgt_ready_o && qa_idx_o == IW'(2)) begin clear_i = 1'b1; hit = 1'b1; end
      step();
      clear_i = 1'b0;
    end
    chk("clear_reached_qa2", hit, 1);
    chk("clear_outputs", {act_ready_o, wgt_ready_o, norm_ready_o, out_valid_o, acc_clear_o,
                          acc_en_o, kin_idx_o, qa_idx_o, qw_idx_o, busy_o, done_o}, '0);
    for (int i = 0; i < 6; i++) begin drive(100, 0); step(); end
    chk("clear_no_done", done_cnt, 0);
    chk("clear_stays_idle", busy_o, 0);
    run(1, 2, 2, 1, 60, 1, -1);
    check_run("after_clear", 1, 2, 2, 1);

    // reset in STREAM with part of the mask set
    clear_stats();
    cfg_nb_kin_i = CW'(1); cfg_qa_i = QCW'(1); cfg_qw_i = QCW'(1); cfg_norm_en_i = 1'b0;
    start_i = 1'b1; drive(100, 0); out_ready_i = '0; step(); start_i = 1'b0;
    for (int i = 0; i < 20 && !out_valid_o; i++) begin drive(100, 0); out_ready_i = '0; step(); end
    chk("reach_stream", out_valid_o, 1);
    out_ready_i = 9'h0FF; step();
    chk("stream_partial_hold", out_valid_o, 1);
    rst_i = 1'b1; out_ready_i = '0; step(); rst_i = 1'b0;
    chk("rst_stream_outputs", {act_ready_o, wgt_ready_o, norm_ready_o, out_valid_o, acc_clear_o,
                               acc_en_o, kin_idx_o, qa_idx_o, qw_idx_o, busy_o, done_o}, '0);
    chk("rst_no_done", done_cnt, 0);
    pat.delete(); pat.push_back(9'h100); pat.push_back(9'h0FF);
    run(1, 1, 1, 0, 100, 2, -1);
    chk("mask_cleared_by_rst", ov_cnt, 2);
    check_run("after_rst", 1, 1, 1, 0);

    // random configurations
    for (int r = 0; r < 3; r++) begin
      int nb, qa, qw;
      bit ne;
      nb = int'($urandom_range(3, 0));
      qa = int'($urandom_range(15, 0));
      qw = int'($urandom_range(15, 0));
      ne = 1'($urandom_range(1, 0));
      run(nb, qa, qw, ne, 70, 1, -1);
      check_run("rand", nb, qa, qw, ne);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rbe_engine_sequencer.md
Name: rbe_engine_sequencer

Overview:
- Control FSM that sequences one output tile through the engine core: clear accumulators, load activations, then stream weight bit-planes.
- Loops over input-channel tiles (Kin), activation bits (QA) and weight bits (QW).
- Consumes one normalization word, then waits until every column's output stream has been accepted.
- Sits beside the engine core. It gates the activation, weight and norm handshakes and drives the accumulator enable/clear controls.

Parameters:
- NR_COLUMN, 9, number of BinConv columns / output streams.
- CNT_W, 16, width of the Kin tile counter and of cfg_nb_kin_i.
- QMAX, 8, maximum activation/weight precision in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- clear_i  in  1  soft clear; same effect as reset
- start_i  in  1  start pulse; sampled in IDLE only
- cfg_nb_kin_i  in  CNT_W  number of Kin tiles; 0 treated as 1
- cfg_qa_i  in  $clog2(QMAX)+1  activation bits; 0 treated as 1, values above QMAX clamp to QMAX
- cfg_qw_i  in  $clog2(QMAX)+1  weight bits; same clamping as cfg_qa_i
- cfg_norm_en_i  in  1  1 = consume one norm word before streamout
- act_valid_i  in  1  activation tile valid
- act_ready_o  out  1  activation tile ready
- wgt_valid_i  in  1  weight bit-plane valid
- wgt_ready_o  out  1  weight bit-plane ready
- norm_valid_i  in  1  norm word valid
- norm_ready_o  out  1  norm word ready
- out_valid_o  out  1  output valid, broadcast to all columns
- out_ready_i  in  NR_COLUMN  per-column output ready
- acc_clear_o  out  1  accumulator clear pulse
- acc_en_o  out  1  accumulate strobe
- kin_idx_o  out  CNT_W  current Kin tile index
- qa_idx_o  out  $clog2(QMAX)  current activation bit index
- qw_idx_o  out  $clog2(QMAX)  current weight bit index
- busy_o  out  1  high in any state other than IDLE
- done_o  out  1  one-cycle pulse on completion

Behaviour:
- Reset / clear:
  - State = IDLE; all counters = 0; column mask = 0.
  - All outputs = 0 on the cycle after rst_i or clear_i is sampled high.
  - Mid-operation reset/clear aborts silently: no done_o pulse.
  - rst_i/clear_i take priority over every other event.
- Config latch: on start_i in IDLE, cfg_* are latched with clamping applied. Inputs are ignored after that until IDLE is re-entered. start_i outside IDLE is ignored.
- IDLE: on start_i -> CLR.
- CLR: acc_clear_o=1 for exactly one cycle; kin/qa/qw counters reset to 0 -> LOAD.
- LOAD:
  - act_ready_o=1.
  - On act_valid_i & act_ready_o -> COMP.
  - acc_en_o stays 0 in LOAD.
- COMP:
  - wgt_ready_o=1.
  - Each wgt handshake asserts acc_en_o combinationally in the same cycle.
  - Loop order per handshake: qw_idx++. On qw wrap (qw_idx==QW-1): qw_idx=0, qa_idx++.
  - On simultaneous qa wrap and qw wrap:
    - If kin_idx < NB_KIN-1: kin_idx++, qa=qw=0, -> LOAD.
    - Otherwise -> NORM if norm_en, else -> STREAM.
  - Handshakes per Kin tile = QA*QW.
  - Indices shown on *_idx_o are those of the bit-plane currently being accepted.
- NORM: norm_ready_o=1; on handshake -> STREAM.
- STREAM:
  - out_valid_o=1.
  - A sticky NR_COLUMN-bit mask ORs in out_ready_i each cycle.
  - out_valid_o stays high until (mask | out_ready_i) is all-ones. Columns may accept in different cycles; all-ready in one cycle is a single-cycle stream.
  - Then mask=0 -> DONE.
- DONE: done_o=1 for one cycle; busy_o=1 in this cycle -> IDLE.
- Handshake rules:
  - No *_ready_o depends combinationally on the matching *_valid_i.
  - acc_en_o = wgt_valid_i & wgt_ready_o.
  - At most one of act/wgt/norm ready is high in any cycle.
- Latency:
  - start_i to first act_ready_o = 2 cycles (IDLE->CLR->LOAD).
  - Last weight handshake to out_valid_o = 1 cycle (norm disabled).
  - Last column accept to done_o = 1 cycle.

Test Plan:
- NB_KIN=1, QA=QW=1, norm off, all inputs always valid/ready:
  - start at cycle 0 -> acc_clear_o at cycle 1, act handshake at cycle 2, acc_en_o at cycle 3, out_valid_o at cycle 4, done_o at cycle 5.
- NB_KIN=3, QA=4, QW=2, norm on, random valid stalls:
  - Exactly 3 act handshakes and 24 acc_en_o pulses.
  - (kin,qa,qw) sequence (0,0,0),(0,0,1),(0,1,0)...(2,3,1).
  - 1 norm handshake, then done_o.
- STREAM with out_ready_i = 9'h00F, then 9'h0F0, then 9'h100 on successive cycles:
  - out_valid_o high for 3 cycles; done_o on the 4th.
- cfg_qa_i=0, cfg_qw_i=15, cfg_nb_kin_i=0 -> behaves as QA=1, QW=8, NB_KIN=1: 8 acc_en_o pulses.
- start_i asserted while busy -> ignored, latched config unchanged.
  - clear_i asserted in COMP with qa_idx=2 -> IDLE next cycle, all outputs 0, no done_o.
  - A fresh start then completes normally.
- rst_i asserted in STREAM with mask partially set -> mask cleared.
  - The next run requires all 9 columns to accept again before done_o.
